// File: rtl/dispense_pkg.sv
// Shared types and helpers for the dispense sequencer.
package dispense_pkg;

    localparam logic [2:0] ENC_IDLE     = 3'd0;
    localparam logic [2:0] ENC_WAIT_POS = 3'd1;
    localparam logic [2:0] ENC_FILL     = 3'd2;
    localparam logic [2:0] ENC_RETURN   = 3'd3;
    localparam logic [2:0] ENC_FAULT    = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ENC_IDLE,
        WAIT_POS = ENC_WAIT_POS,
        FILL     = ENC_FILL,
        RETURN   = ENC_RETURN,
        FAULT    = ENC_FAULT
    } disp_state_t;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-flop rising-edge detector: rise = in & ~in_q.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise
);

    logic sig_q;
    logic sig_d;

    always_comb sig_d = sig_in;

    // Previous-cycle copy of the input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_q <= 1'b0;
        else        sig_q <= sig_d;
    end

    assign rise = sig_in & ~sig_q;

endmodule

// File: rtl/dispense_sequencer.sv
// Dispense sequencer: drives the motor controller's t input through
// WAIT_POS -> FILL -> RETURN for each requested portion.
// Optional motion watchdog and FAULT state: define DISPENSE_WATCHDOG_EN.
module dispense_sequencer
    import dispense_pkg::*;
#(
    parameter int unsigned PORTIONS_W    = 4,
    parameter int unsigned FILL_TICKS    = 1000,
    parameter int unsigned TIMEOUT_TICKS = 100000
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  start,
    input  logic [PORTIONS_W-1:0] portions,
    input  logic                  abort,
    input  logic                  fill_start,
    input  logic                  cycle_done,
    output logic                  t,
    output logic                  busy,
    output logic                  done,
    output logic                  fault,
    output logic [PORTIONS_W-1:0] remaining
);

    localparam int unsigned DW = cnt_width(FILL_TICKS - 1);

    disp_state_t           state_q, state_d;
    logic [DW-1:0]         dwell_q, dwell_d;
    logic [PORTIONS_W-1:0] remaining_q, remaining_d;
    logic [PORTIONS_W-1:0] rem_dec;
    logic                  t_q, t_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  fault_q, fault_d;
    logic                  fill_rise, done_rise;
    logic                  wd_expired;

    rise_detect u_fill_rise (
        .clk    (CLK),
        .rst_n  (RST_N),
        .sig_in (fill_start),
        .rise   (fill_rise)
    );

    rise_detect u_done_rise (
        .clk    (CLK),
        .rst_n  (RST_N),
        .sig_in (cycle_done),
        .rise   (done_rise)
    );

    assign rem_dec = remaining_q - PORTIONS_W'(1);

`ifdef DISPENSE_WATCHDOG_EN
    localparam int unsigned WD_W = cnt_width(TIMEOUT_TICKS);

    logic [WD_W-1:0] wd_q, wd_d;

    assign wd_expired = (wd_q == WD_W'(TIMEOUT_TICKS - 1));

    // Watchdog: counts cycles in a motion state, clears on any state change, saturates.
    always_comb begin
        wd_d = '0;
        if (state_d == state_q && (state_q == WAIT_POS || state_q == RETURN)) begin
            wd_d = (wd_q == '1) ? wd_q : wd_q + WD_W'(1);
        end
    end

    // Watchdog counter register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) wd_q <= '0;
        else        wd_q <= wd_d;
    end
`else
    assign wd_expired = 1'b0;

    if (TIMEOUT_TICKS == 0) begin : g_timeout_unused
    end
`endif

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d     = state_q;
        dwell_d     = dwell_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (portions != '0) begin
                        remaining_d = portions;
                        state_d     = WAIT_POS;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            WAIT_POS: begin
                if (fill_rise) begin
                    state_d = FILL;
                    dwell_d = DW'(FILL_TICKS - 1);
                end else if (wd_expired) begin
                    state_d = FAULT;
                end
            end
            FILL: begin
                if (dwell_q == '0) state_d = RETURN;
                else               dwell_d = dwell_q - DW'(1);
            end
            RETURN: begin
                if (done_rise) begin
                    remaining_d = rem_dec;
                    if (rem_dec == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WAIT_POS;
                    end
                end else if (wd_expired) begin
                    state_d = FAULT;
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d     = IDLE;
            dwell_d     = '0;
            remaining_d = '0;
            done_d      = 1'b0;
        end

        // Outputs follow the next state so they are registered, not decoded.
        t_d    = (state_d == WAIT_POS) || (state_d == RETURN);
        busy_d = (state_d == WAIT_POS) || (state_d == FILL) || (state_d == RETURN);
`ifdef DISPENSE_WATCHDOG_EN
        fault_d = (state_d == FAULT);
`else
        fault_d = 1'b0;
`endif
    end

    // State, counter and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            dwell_q     <= '0;
            remaining_q <= '0;
            t_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            remaining_q <= remaining_d;
            t_q         <= t_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
        end
    end

    assign t         = t_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign remaining = remaining_q;

endmodule

// File: tb/tb_dispense_sequencer.sv
// Directed testbench for dispense_sequencer (FILL_TICKS=4, TIMEOUT_TICKS=20).
module tb_dispense_sequencer;

    localparam int unsigned PW      = 4;
    localparam int unsigned FILL    = 4;
    localparam int unsigned TIMEOUT = 20;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          start = 1'b0;
    logic [PW-1:0] portions = '0;
    logic          abort = 1'b0;
    logic          fill_start = 1'b0;
    logic          cycle_done = 1'b0;
    logic          t, busy, done, fault;
    logic [PW-1:0] remaining;

    int n_vec  = 0;
    int n_miss = 0;

    dispense_sequencer #(
        .PORTIONS_W    (PW),
        .FILL_TICKS    (FILL),
        .TIMEOUT_TICKS (TIMEOUT)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .start      (start),
        .portions   (portions),
        .abort      (abort),
        .fill_start (fill_start),
        .cycle_done (cycle_done),
        .t          (t),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .remaining  (remaining)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Pulse fill_start from WAIT_POS and measure how many cycles t stays low.
    task automatic run_fill(output int fill_len);
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        fill_len = 0;
        for (int i = 0; i < 20; i++) begin
            if (t !== 1'b0) break;
            fill_len++;
            step();
        end
    endtask

    task automatic pulse_cycle_done();
        cycle_done = 1'b1;
        step();
        cycle_done = 1'b0;
    endtask

    initial begin
        int flen;

        // Reset
        repeat (2) step();
        check("rst_t", t, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fault", fault, 0);
        check("rst_rem", remaining, 0);
        RST_N = 1'b1;
        step();

        // One portion
        portions = 4'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("p1_t", t, 1);
        check("p1_busy", busy, 1);
        check("p1_rem", remaining, 1);
        step();
        check("p1_wait_t", t, 1);
        run_fill(flen);
        check("p1_fill_len", flen, FILL);
        check("p1_ret_t", t, 1);
        pulse_cycle_done();
        check("p1_done", done, 1);
        check("p1_rem0", remaining, 0);
        check("p1_busy0", busy, 0);
        check("p1_t0", t, 0);
        step();
        check("p1_done_drop", done, 0);

        // Three portions
        portions = 4'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        check("p3_rem3", remaining, 3);
        for (int p = 0; p < 3; p++) begin
            step();
            check("p3_wait_t", t, 1);
            run_fill(flen);
            check("p3_fill_len", flen, FILL);
            pulse_cycle_done();
            check("p3_rem", remaining, 32'(2 - p));
            check("p3_done", done, (p == 2) ? 1 : 0);
            check("p3_busy", busy, (p == 2) ? 0 : 1);
        end
        step();
        check("p3_done_drop", done, 0);

        // Zero portions
        portions = 4'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("p0_done", done, 1);
        check("p0_busy", busy, 0);
        check("p0_t", t, 0);
        step();
        check("p0_done_drop", done, 0);
        check("p0_busy2", busy, 0);
        check("p0_t2", t, 0);

        // Abort in FILL with start in the same cycle
        portions = 4'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        step();
        check("ab_in_fill_t", t, 0);
        check("ab_in_fill_busy", busy, 1);
        abort = 1'b1;
        start = 1'b1;
        portions = 4'd5;
        step();
        abort = 1'b0;
        start = 1'b0;
        check("ab_t", t, 0);
        check("ab_busy", busy, 0);
        check("ab_rem", remaining, 0);
        check("ab_done", done, 0);
        step();
        check("ab_busy2", busy, 0);
        check("ab_rem2", remaining, 0);
        check("ab_done2", done, 0);

        // Watchdog (or its absence)
        portions = 4'd1;
        start = 1'b1;
        step();
        start = 1'b0;
`ifdef DISPENSE_WATCHDOG_EN
        for (int k = 2; k <= 20; k++) step();
        check("wd_c20_fault", fault, 0);
        check("wd_c20_t", t, 1);
        step();
        check("wd_c21_fault", fault, 1);
        check("wd_c21_t", t, 0);
        check("wd_c21_busy", busy, 0);
        portions = 4'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        check("wd_start_ign_fault", fault, 1);
        check("wd_start_ign_busy", busy, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("wd_abort_fault", fault, 0);
        check("wd_abort_busy", busy, 0);
        check("wd_abort_rem", remaining, 0);
`else
        repeat (40) step();
        check("nowd_fault", fault, 0);
        check("nowd_t", t, 1);
        check("nowd_busy", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("nowd_abort_busy", busy, 0);
`endif

        // Async reset during RETURN
        portions = 4'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        run_fill(flen);
        check("rr_fill_len", flen, FILL);
        check("rr_ret_t", t, 1);
        check("rr_ret_rem", remaining, 2);
        #2;
        RST_N = 1'b0;
        #1;
        check("rr_t", t, 0);
        check("rr_busy", busy, 0);
        check("rr_done", done, 0);
        check("rr_fault", fault, 0);
        check("rr_rem", remaining, 0);
        step();
        RST_N = 1'b1;
        pulse_cycle_done();
        check("rr_stray_done", done, 0);
        check("rr_stray_busy", busy, 0);
        step();
        check("rr_stray_done2", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
